// File: rtl/seg7_scan_capture_if.sv
// Display bus snooped by seg7_scan_capture: active-low anode/segment inputs and
// the rebuilt frame outputs. The slave side is the capture block.
interface seg7_scan_capture_if;
    logic [7:0]  disp_an_i;
    logic [7:0]  disp_seg_i;
    logic [63:0] frame_seg_o;
    logic [31:0] frame_hex_o;
    logic [7:0]  hex_ok_o;
    logic        frame_valid_o;
    logic        scan_err_o;
    logic        timeout_o;

    modport master (
        output disp_an_i, disp_seg_i,
        input  frame_seg_o, frame_hex_o, hex_ok_o, frame_valid_o, scan_err_o, timeout_o
    );

    modport slave (
        input  disp_an_i, disp_seg_i,
        output frame_seg_o, frame_hex_o, hex_ok_o, frame_valid_o, scan_err_o, timeout_o
    );
endinterface

// File: rtl/seg7_scan_capture.sv
// Rebuilds the 8-digit frame shown on a multiplexed active-low 7-segment bus,
// checks the scan order and decodes each digit back to a hex nibble.
module seg7_scan_capture #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_capture_if.slave scan_if
);
    localparam int unsigned      RUN_W    = $clog2(STABLE_CYCLES + 2);
    localparam int unsigned      TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_FIRE = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;

    state_t           state_q;
    logic [7:0]       an_q, seg_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic [2:0]       exp_q;
    logic [63:0]      shadow_q, frame_seg_q;
    logic [31:0]      frame_hex_q;
    logic [7:0]       hex_ok_q;
    logic             frame_valid_q, scan_err_q, timeout_q;
    logic             sample, is_digit, is_blank;
    logic [2:0]       digit;

    // Returns {match, nibble}; the decimal point (bit 7) plays no part.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40:   decode = 5'h10;
            7'h79:   decode = 5'h11;
            7'h24:   decode = 5'h12;
            7'h30:   decode = 5'h13;
            7'h19:   decode = 5'h14;
            7'h12:   decode = 5'h15;
            7'h02:   decode = 5'h16;
            7'h78:   decode = 5'h17;
            7'h00:   decode = 5'h18;
            7'h10:   decode = 5'h19;
            7'h08:   decode = 5'h1A;
            7'h03:   decode = 5'h1B;
            7'h46:   decode = 5'h1C;
            7'h21:   decode = 5'h1D;
            7'h06:   decode = 5'h1E;
            7'h0E:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        run_d  = (scan_if.disp_an_i != an_q) ? RUN_W'(1)
               : ((run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1));
        tcnt_d = (tcnt_q == TO_MAX) ? tcnt_q : tcnt_q + TO_W'(1);
        // Run saturates one past the threshold so exactly one sample fires per dwell.
        sample   = (run_q == RUN_FIRE);
        is_digit = $onehot(~an_q);
        is_blank = (an_q == '1);
        digit    = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (!an_q[k]) digit = 3'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= '1;
            run_q <= '0;
        end else begin
            an_q  <= scan_if.disp_an_i;
            seg_q <= scan_if.disp_seg_i;
            run_q <= run_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            exp_q         <= '0;
            shadow_q      <= '1;
            tcnt_q        <= '0;
            frame_seg_q   <= '1;
            frame_hex_q   <= '0;
            hex_ok_q      <= '0;
            frame_valid_q <= 1'b0;
            scan_err_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            if (state_q == COMMIT) begin
                tcnt_q        <= '0;
                timeout_q     <= 1'b0;
                frame_seg_q   <= shadow_q;
                frame_valid_q <= 1'b1;
                for (int unsigned k = 0; k < 8; k++) begin
                    {hex_ok_q[k], frame_hex_q[4*k +: 4]} <= decode(shadow_q[8*k +: 7]);
                end
                exp_q   <= '0;
                state_q <= CAPTURE;
            end else begin
                tcnt_q <= tcnt_d;
                if (tcnt_d == TO_MAX) timeout_q <= 1'b1;
                if (sample && is_digit) begin
                    if (state_q == IDLE) begin
                        if (digit == 3'd0) begin
                            shadow_q[7:0] <= seg_q;
                            exp_q         <= 3'd1;
                            state_q       <= CAPTURE;
                        end
                    end else if (digit == exp_q) begin
                        shadow_q[8*exp_q +: 8] <= seg_q;
                        exp_q                  <= exp_q + 3'd1;
                        if (exp_q == 3'd7) state_q <= COMMIT;
                    end else begin
                        scan_err_q <= 1'b1;
                        if (digit == 3'd0) begin
                            shadow_q[7:0] <= seg_q;
                            exp_q         <= 3'd1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end else if (sample && !is_blank) begin
                    scan_err_q <= 1'b1;
                    state_q    <= IDLE;
                end
            end
        end
    end

    assign scan_if.frame_seg_o   = frame_seg_q;
    assign scan_if.frame_hex_o   = frame_hex_q;
    assign scan_if.hex_ok_o      = hex_ok_q;
    assign scan_if.frame_valid_o = frame_valid_q;
    assign scan_if.scan_err_o    = scan_err_q;
    assign scan_if.timeout_o     = timeout_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: scans are driven on the display bus,
// expected frames go into a queue and a negedge monitor checks each frame pulse.
module tb_seg7_scan_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_capture_if bus ();

    seg7_scan_capture #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .scan_if(bus)
    );

    typedef struct {
        logic [63:0] seg;
        logic [31:0] hex;
        logic [7:0]  ok;
    } frame_t;

    frame_t exp_q[$];
    int     tests = 0;
    int     fails = 0;
    logic   prev_valid = 1'b0;

    // Digit k at [8k+7:8k]
    localparam logic [63:0] IMG_HEX07 = 64'hF882_9299_B0A4_F9C0;
    localparam logic [63:0] IMG_BLANK = 64'hF882_9299_FFA4_F9C0;
    localparam logic [63:0] IMG_HEX8F = 64'h8E86_A1C6_8388_9000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_seg"},   bus.frame_seg_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check({tag, "_hex"},   64'(bus.frame_hex_o), 64'h0);
        check({tag, "_ok"},    64'(bus.hex_ok_o), 64'h0);
        check({tag, "_valid"}, 64'(bus.frame_valid_o), 64'h0);
        check({tag, "_err"},   64'(bus.scan_err_o), 64'h0);
        check({tag, "_tmo"},   64'(bus.timeout_o), 64'h0);
    endtask

    // Called at posedge+1; holds the digit for dwell cycles and returns at posedge+1.
    task automatic drive_an(input logic [7:0] an, input logic [7:0] seg, input int unsigned dwell);
        bus.disp_an_i  = an;
        bus.disp_seg_i = seg;
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int unsigned k, input logic [7:0] seg, input int unsigned dwell);
        logic [7:0] one;
        one = 8'd1;
        drive_an(~(one << k), seg, dwell);
    endtask

    task automatic scan(input logic [63:0] img, input int unsigned dwell,
                        input bit expect_frame, input logic [31:0] hex, input logic [7:0] ok);
        frame_t f;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k == 7 && expect_frame) begin
                f.seg = img;
                f.hex = hex;
                f.ok  = ok;
                exp_q.push_back(f);
            end
            drive_digit(k, img[8*k +: 8], dwell);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.frame_valid_o) begin
                frame_t f;
                check("valid_one_cycle", 64'(prev_valid), 64'h0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got frame_valid_o=1 hex=%h, expected no frame",
                             bus.frame_hex_o);
                end else begin
                    f = exp_q.pop_front();
                    check("frame_seg", bus.frame_seg_o, f.seg);
                    check("frame_hex", 64'(bus.frame_hex_o), 64'(f.hex));
                    check("hex_ok",    64'(bus.hex_ok_o), 64'(f.ok));
                    check("frame_tmo", 64'(bus.timeout_o), 64'h0);
                end
            end
            prev_valid = bus.frame_valid_o;
        end
    end

    initial begin
        bus.disp_an_i  = 8'hFF;
        bus.disp_seg_i = 8'hFF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("t1_reset");

        // T1: clean "01234567"
        scan(IMG_HEX07, 8, 1'b1, 32'h7654_3210, 8'hFF);
        scan(IMG_HEX07, 8, 1'b1, 32'h7654_3210, 8'hFF);

        // T2: digit 3 blank glyph
        scan(IMG_BLANK, 8, 1'b1, 32'h7654_0210, 8'hF7);

        // T3: dwell too short to sample, then timeout and recovery
        for (int i = 0; i < 4; i++) scan(IMG_HEX07, 3, 1'b0, '0, '0);
        check("t3_tmo_early", 64'(bus.timeout_o), 64'h0);
        for (int i = 0; i < 8; i++) scan(IMG_HEX07, 3, 1'b0, '0, '0);
        check("t3_tmo_set", 64'(bus.timeout_o), 64'h1);
        check("t3_err_clear", 64'(bus.scan_err_o), 64'h0);
        scan(IMG_HEX07, 8, 1'b1, 32'h7654_3210, 8'hFF);
        check("t3_tmo_cleared", 64'(bus.timeout_o), 64'h0);

        // T4: two anodes low mid-frame
        for (int unsigned k = 0; k < 3; k++) drive_digit(k, IMG_HEX07[8*k +: 8], 8);
        drive_an(8'hFC, 8'hC0, 8);
        check("t4_err_set", 64'(bus.scan_err_o), 64'h1);
        for (int unsigned k = 3; k < 8; k++) drive_digit(k, IMG_HEX07[8*k +: 8], 8);
        scan(IMG_HEX07, 8, 1'b1, 32'h7654_3210, 8'hFF);
        check("t4_err_sticky", 64'(bus.scan_err_o), 64'h1);

        // T6: reset while digit 4 dwells
        for (int unsigned k = 0; k < 4; k++) drive_digit(k, IMG_HEX8F[8*k +: 8], 8);
        drive_digit(4, IMG_HEX8F[39:32], 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("t6_reset");
        drive_digit(4, IMG_HEX8F[39:32], 4);
        for (int unsigned k = 5; k < 8; k++) drive_digit(k, IMG_HEX8F[8*k +: 8], 8);
        check("t6_no_frame_seg", bus.frame_seg_o, 64'hFFFF_FFFF_FFFF_FFFF);
        scan(IMG_HEX07, 8, 1'b1, 32'h7654_3210, 8'hFF);

        // T5: order 0,1,2,5 then resync on digit 0
        for (int unsigned k = 0; k < 3; k++) drive_digit(k, IMG_HEX8F[8*k +: 8], 8);
        drive_digit(5, IMG_HEX8F[47:40], 8);
        check("t5_err_set", 64'(bus.scan_err_o), 64'h1);
        drive_digit(6, IMG_HEX8F[55:48], 8);
        drive_digit(7, IMG_HEX8F[63:56], 8);
        scan(IMG_HEX8F, 8, 1'b1, 32'hFEDC_BA98, 8'hFF);
        scan(IMG_HEX07, 8, 1'b1, 32'h7654_3210, 8'hFF);

        drive_an(8'hFF, 8'hFF, 10);
        check("all_frames_seen", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
